// File: rtl/monitor_decimal_pkg.sv
// Shared definitions for the decimal 7-segment driver and its loopback reader.
// Holds the active-low segment codes, the active-low digit select encodings,
// the rejected-frame cause codes and the reader FSM state encoding.
package monitor_decimal_pkg;

    // seg[6:0] = {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [2:0] SEL_UNI  = 3'b110;
    localparam logic [2:0] SEL_DEC  = 3'b101;
    localparam logic [2:0] SEL_CEN  = 3'b011;
    localparam logic [2:0] SEL_NONE = 3'b111;

    localparam logic [1:0] ERR_NINGUNO  = 2'b00;
    localparam logic [1:0] ERR_PATRON   = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_BLANKING = 2'b11;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_CALC    = 2'd1,
        ST_EMIT    = 2'd2
    } estado_t;

    // Three BCD digits to binary; 999 fits in 10 bits.
    function automatic logic [9:0] bcd3_a_bin(input logic [3:0] cen,
                                              input logic [3:0] dec,
                                              input logic [3:0] uni);
        return (10'(cen) * 10'd100) + (10'(dec) * 10'd10) + 10'(uni);
    endfunction

endpackage

// File: rtl/seg7_a_bcd.sv
// Combinational 7-segment (active-low) to BCD decoder.
//   seg_i      : segment pattern {g..a}
//   bcd_o      : decoded digit, 0 for blank or invalid patterns
//   blank_o    : all segments off
//   invalido_o : pattern is neither a digit nor blank
module seg7_a_bcd
    import monitor_decimal_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] bcd_o,
    output logic       blank_o,
    output logic       invalido_o
);

    always_comb begin
        bcd_o      = 4'd0;
        blank_o    = 1'b0;
        invalido_o = 1'b0;
        case (seg_i)
            SEG_0:     bcd_o = 4'd0;
            SEG_1:     bcd_o = 4'd1;
            SEG_2:     bcd_o = 4'd2;
            SEG_3:     bcd_o = 4'd3;
            SEG_4:     bcd_o = 4'd4;
            SEG_5:     bcd_o = 4'd5;
            SEG_6:     bcd_o = 4'd6;
            SEG_7:     bcd_o = 4'd7;
            SEG_8:     bcd_o = 4'd8;
            SEG_9:     bcd_o = 4'd9;
            SEG_BLANK: blank_o = 1'b1;
            default:   invalido_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/monitor_decimal_lector.sv
// Loopback reader for the multiplexed 3-digit decimal 7-segment driver.
// Samples the scanned segment bus, accepts each digit after a stable dwell,
// and once all three slots are filled decodes the frame and either reports
// the value (valido pulse) or rejects it (error_trama pulse + cause code).
//   clock_placa  : system clock, rising edge
//   reset        : synchronous, active-high
//   reg7SEG      : segment bus, active-low, [7]=dp (ignored)
//   sel_pantalla : digit select, one-hot active-low
//   valor        : last successfully decoded value
//   valido       : one-cycle pulse when valor updates
//   error_trama  : one-cycle pulse on a rejected frame
//   codigo_error : cause of the last rejected frame
//
// state      | meaning
// ST_COLLECT | digit acceptance active, waiting for all three slots
// ST_CALC    | decode slots and compute value/errors, acceptance frozen
// ST_EMIT    | pulse result, clear mask and dwell counter
module monitor_decimal_lector
    import monitor_decimal_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clock_placa,
    input  logic             reset,
    input  logic [7:0]       reg7SEG,
    input  logic [2:0]       sel_pantalla,
    output logic [WIDTH-1:0] valor,
    output logic             valido,
    output logic             error_trama,
    output logic [1:0]       codigo_error
);

    localparam logic [7:0]  STAB = 8'(STABLE_CYCLES);
    localparam int unsigned MAXV = (WIDTH >= 10) ? 32'd1023 : ((32'd1 << WIDTH) - 32'd1);

    logic [6:0]       seg_q;
    logic [2:0]       sel_q;
    logic [9:0]       prev_q;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       mask_q, mask_d;
    logic [6:0]       slot_uni_q, slot_uni_d;
    logic [6:0]       slot_dec_q, slot_dec_d;
    logic [6:0]       slot_cen_q, slot_cen_d;
    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] valor_q, valor_d;
    logic [1:0]       code_q, code_d;
    logic             ok_q, ok_d;

    logic unused_dp;
    assign unused_dp = reg7SEG[7];

    logic [3:0] bcd_uni, bcd_dec, bcd_cen;
    logic       blank_uni, blank_dec, blank_cen;
    logic       inv_uni, inv_dec, inv_cen;

    seg7_a_bcd u_dec_uni (.seg_i(slot_uni_q), .bcd_o(bcd_uni), .blank_o(blank_uni), .invalido_o(inv_uni));
    seg7_a_bcd u_dec_dec (.seg_i(slot_dec_q), .bcd_o(bcd_dec), .blank_o(blank_dec), .invalido_o(inv_dec));
    seg7_a_bcd u_dec_cen (.seg_i(slot_cen_q), .bcd_o(bcd_cen), .blank_o(blank_cen), .invalido_o(inv_cen));

    logic [9:0] muestra;
    logic       sel_ok, igual, acepta;
    logic [9:0] suma;
    logic       err_patron, err_blank, err_ovf;

    assign muestra = {sel_q, seg_q};
    assign sel_ok  = (sel_q == SEL_UNI) || (sel_q == SEL_DEC) || (sel_q == SEL_CEN);
    assign igual   = (muestra == prev_q);

    // Blank leading digits decode as 0, so they drop out of the sum naturally.
    assign suma       = bcd3_a_bin(bcd_cen, bcd_dec, bcd_uni);
    assign err_patron = inv_uni | inv_dec | inv_cen | blank_uni;
    assign err_blank  = blank_dec & ~blank_cen;
    assign err_ovf    = 32'(suma) > MAXV;

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        slot_uni_d = slot_uni_q;
        slot_dec_d = slot_dec_q;
        slot_cen_d = slot_cen_q;
        valor_d    = valor_q;
        code_d     = code_q;
        ok_d       = ok_q;

        if (!sel_ok) begin
            cnt_d = 8'd0;
        end else if (igual) begin
            cnt_d = (cnt_q >= STAB) ? cnt_q : cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd1;
        end

        // Fires once per dwell: on reaching STAB, not while saturated there.
        // A changed sample with STAB==1 reaches it immediately.
        acepta = (estado_q == ST_COLLECT) && sel_ok && (cnt_d == STAB) &&
                 !(igual && (cnt_q == STAB));

        if (acepta) begin
            case (sel_q)
                SEL_UNI: begin slot_uni_d = seg_q; mask_d[0] = 1'b1; end
                SEL_DEC: begin slot_dec_d = seg_q; mask_d[1] = 1'b1; end
                SEL_CEN: begin slot_cen_d = seg_q; mask_d[2] = 1'b1; end
                default: ;
            endcase
        end

        case (estado_q)
            ST_COLLECT: begin
                if (mask_q == 3'b111) estado_d = ST_CALC;
            end
            ST_CALC: begin
                estado_d = ST_EMIT;
                ok_d     = 1'b0;
                if (err_patron) begin
                    code_d = ERR_PATRON;
                end else if (err_blank) begin
                    code_d = ERR_BLANKING;
                end else if (err_ovf) begin
                    code_d = ERR_OVERFLOW;
                end else begin
                    ok_d    = 1'b1;
                    valor_d = WIDTH'(suma);
                end
            end
            ST_EMIT: begin
                estado_d = ST_COLLECT;
                mask_d   = 3'b000;
                cnt_d    = 8'd0;
            end
            default: estado_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clock_placa) begin
        if (reset) begin
            seg_q      <= SEG_BLANK;
            sel_q      <= SEL_NONE;
            prev_q     <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
            slot_uni_q <= SEG_BLANK;
            slot_dec_q <= SEG_BLANK;
            slot_cen_q <= SEG_BLANK;
            estado_q   <= ST_COLLECT;
            valor_q    <= '0;
            code_q     <= ERR_NINGUNO;
            ok_q       <= 1'b0;
        end else begin
            seg_q      <= reg7SEG[6:0];
            sel_q      <= sel_pantalla;
            prev_q     <= muestra;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            slot_uni_q <= slot_uni_d;
            slot_dec_q <= slot_dec_d;
            slot_cen_q <= slot_cen_d;
            estado_q   <= estado_d;
            valor_q    <= valor_d;
            code_q     <= code_d;
            ok_q       <= ok_d;
        end
    end

    assign valor        = valor_q;
    assign valido       = (estado_q == ST_EMIT) &&  ok_q;
    assign error_trama  = (estado_q == ST_EMIT) && !ok_q;
    assign codigo_error = code_q;

endmodule

// File: tb/tb_monitor_decimal_lector.sv
module tb_monitor_decimal_lector;
    import monitor_decimal_pkg::*;

    localparam int WIDTH = 8;
    localparam int STAB  = 4;
    // input register + dwell to acceptance + CALC + EMIT
    localparam int LAT   = 1 + STAB + 2;

    logic             clock_placa = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       reg7SEG = 8'hFF;
    logic [2:0]       sel_pantalla = 3'b111;
    logic [WIDTH-1:0] valor;
    logic             valido;
    logic             error_trama;
    logic [1:0]       codigo_error;

    monitor_decimal_lector #(.WIDTH(WIDTH), .STABLE_CYCLES(STAB)) dut (
        .clock_placa (clock_placa),
        .reset       (reset),
        .reg7SEG     (reg7SEG),
        .sel_pantalla(sel_pantalla),
        .valor       (valor),
        .valido      (valido),
        .error_trama (error_trama),
        .codigo_error(codigo_error)
    );

    always #5 clock_placa = ~clock_placa;

    int cyc = 0;
    always @(posedge clock_placa) cyc <= cyc + 1;

    int n_ok = 0, n_err = 0, n_both = 0, pulse_cyc = -1;
    always @(negedge clock_placa) begin
        if (valido)      begin n_ok++;  pulse_cyc = cyc; end
        if (error_trama) begin n_err++; pulse_cyc = cyc; end
        if (valido && error_trama) n_both++;
    end

    int total = 0, bad = 0;
    int ustart = 0;

    task automatic check(input string name, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic hold(input logic [6:0] seg, input logic [2:0] sel, input int n);
        for (int i = 0; i < n; i++) begin
            reg7SEG      = {1'($urandom_range(0, 1)), seg};
            sel_pantalla = sel;
            @(negedge clock_placa);
        end
    endtask

    task automatic send_frame(input logic [6:0] h, input logic [6:0] t, input logic [6:0] u);
        hold(h, SEL_CEN, 6);
        hold(SEG_BLANK, SEL_NONE, 2);
        hold(t, SEL_DEC, 6);
        hold(SEG_BLANK, SEL_NONE, 2);
        ustart = cyc;
        hold(u, SEL_UNI, 6);
        hold(SEG_BLANK, SEL_NONE, 6);
    endtask

    typedef struct {
        logic [6:0] h, t, u;
        bit         ok;
        int         val;
        logic [1:0] code;
    } vec_t;

    vec_t v[13];
    int   exp_val, exp_code, ok0, err0;

    initial begin
        v[0]  = '{h:7'h24, t:7'h12, u:7'h19, ok:1, val:254, code:2'b00};
        v[1]  = '{h:7'h7F, t:7'h7F, u:7'h40, ok:1, val:0,   code:2'b00};
        v[2]  = '{h:7'h30, t:7'h40, u:7'h40, ok:0, val:0,   code:2'b10};
        v[3]  = '{h:7'h40, t:7'h40, u:7'h7E, ok:0, val:0,   code:2'b01};
        v[4]  = '{h:7'h79, t:7'h7F, u:7'h40, ok:0, val:0,   code:2'b11};
        v[5]  = '{h:7'h7F, t:7'h79, u:7'h12, ok:1, val:15,  code:2'b00};
        v[6]  = '{h:7'h02, t:7'h7F, u:7'h7F, ok:0, val:0,   code:2'b01};
        v[7]  = '{h:7'h24, t:7'h12, u:7'h12, ok:1, val:255, code:2'b00};
        v[8]  = '{h:7'h24, t:7'h12, u:7'h02, ok:0, val:0,   code:2'b10};
        v[9]  = '{h:7'h7F, t:7'h7F, u:7'h7F, ok:0, val:0,   code:2'b01};
        v[10] = '{h:7'h7E, t:7'h40, u:7'h40, ok:0, val:0,   code:2'b01};
        v[11] = '{h:7'h00, t:7'h10, u:7'h78, ok:0, val:0,   code:2'b10};
        v[12] = '{h:7'h7F, t:7'h30, u:7'h00, ok:1, val:38,  code:2'b00};

        hold(SEG_BLANK, SEL_NONE, 3);
        check("reset valor", int'(valor), 0);
        check("reset valido", int'(valido), 0);
        check("reset error_trama", int'(error_trama), 0);
        check("reset codigo_error", int'(codigo_error), 0);
        reset = 1'b0;
        hold(SEG_BLANK, SEL_NONE, 2);

        exp_val  = 0;
        exp_code = 0;
        for (int i = 0; i < 13; i++) begin
            ok0  = n_ok;
            err0 = n_err;
            send_frame(v[i].h, v[i].t, v[i].u);
            if (v[i].ok) exp_val = v[i].val;
            else         exp_code = int'(v[i].code);
            check($sformatf("v%0d valido pulses", i), n_ok - ok0, v[i].ok ? 1 : 0);
            check($sformatf("v%0d error pulses", i), n_err - err0, v[i].ok ? 0 : 1);
            check($sformatf("v%0d valor", i), int'(valor), exp_val);
            check($sformatf("v%0d codigo_error", i), int'(codigo_error), exp_code);
            check($sformatf("v%0d latency", i), pulse_cyc - ustart, LAT);
        end

        // Glitches one cycle short of acceptance on tens and on units.
        ok0  = n_ok;
        err0 = n_err;
        hold(SEG_0, SEL_CEN, 6);
        hold(SEG_BLANK, SEL_NONE, 2);
        hold(SEG_2, SEL_DEC, STAB - 1);
        hold(SEG_3, SEL_DEC, STAB);
        hold(SEG_BLANK, SEL_NONE, 2);
        hold(SEG_9, SEL_UNI, STAB - 1);
        ustart = cyc;
        hold(SEG_1, SEL_UNI, 6);
        hold(SEG_BLANK, SEL_NONE, 6);
        check("glitch valido pulses", n_ok - ok0, 1);
        check("glitch error pulses", n_err - err0, 0);
        check("glitch valor", int'(valor), 31);
        check("glitch latency", pulse_cyc - ustart, LAT);

        // Reset after two digits accepted: partial frame must be discarded.
        ok0  = n_ok;
        err0 = n_err;
        hold(SEG_2, SEL_CEN, 6);
        hold(SEG_BLANK, SEL_NONE, 2);
        hold(SEG_1, SEL_DEC, 6);
        hold(SEG_BLANK, SEL_NONE, 2);
        reset = 1'b1;
        hold(SEG_BLANK, SEL_NONE, 2);
        reset = 1'b0;
        check("midreset valor", int'(valor), 0);
        check("midreset codigo_error", int'(codigo_error), 0);
        hold(SEG_0, SEL_UNI, 6);
        hold(SEG_BLANK, SEL_NONE, 6);
        check("midreset stale mask pulses", (n_ok - ok0) + (n_err - err0), 0);
        hold(SEG_9, SEL_UNI, 6);
        hold(SEG_BLANK, SEL_NONE, 2);
        hold(SEG_9, SEL_DEC, 6);
        hold(SEG_BLANK, SEL_NONE, 2);
        ustart = cyc;
        hold(SEG_BLANK, SEL_CEN, 6);
        hold(SEG_BLANK, SEL_NONE, 6);
        check("postreset valido pulses", n_ok - ok0, 1);
        check("postreset error pulses", n_err - err0, 0);
        check("postreset valor", int'(valor), 99);
        check("postreset latency", pulse_cyc - ustart, LAT);

        // Reset sampled on the edge that would enter EMIT: no pulse.
        ok0  = n_ok;
        err0 = n_err;
        hold(SEG_2, SEL_CEN, 6);
        hold(SEG_BLANK, SEL_NONE, 2);
        hold(SEG_1, SEL_DEC, 6);
        hold(SEG_BLANK, SEL_NONE, 2);
        hold(SEG_1, SEL_UNI, 6);
        reset = 1'b1;
        hold(SEG_BLANK, SEL_NONE, 2);
        reset = 1'b0;
        hold(SEG_BLANK, SEL_NONE, 4);
        check("emit reset pulses", (n_ok - ok0) + (n_err - err0), 0);
        check("emit reset valor", int'(valor), 0);

        check("valido and error together", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
